bvmul_pred_witness: RTL and testbench

Sequential witness generator for the bit-vector constraint "pred(a·x, b)" over WIDTH-bit operands, where the product is truncated mod 2^WIDTH. It is the parametrised successor to our fixed 4-bit combinational Skolem function for bvsge/bvmul. It widens the operands and selects the predicate at run time. Instead of one decision bit, it returns the least satisfying x, or reports unsatisfiable after an exhaustive search. It sits behind the solver-side harness as a reference oracle for checking synthesised Skolem circuits.

---
 rtl/bvmul_pred_witness.sv | 133 +++++++++++++
 tb/tb_bvmul_pred_witness.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bvmul_pred_witness.sv
// Purpose: least-witness search for pred(a*x mod 2^WIDTH, b) over x = 0..2^WIDTH-1.
// Latency: least witness k -> done after E0+k+1; unsatisfiable -> done after E0+2^WIDTH.
// Backpressure: start is taken only while ready=1 (IDLE); start is ignored during a search.
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   start, abort          request (taken in IDLE) / cancel a running search
//   a, b, pred            multiplicand, bound, predicate select (0 sge, 1 sgt, 2 uge, 3 eq)
//   ready, done, found, x IDLE flag, completion pulse, satisfiable flag, least witness
module bvmul_pred_witness #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       pred,
  output logic             ready,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] x
);

  typedef enum logic {IDLE, SEARCH} state_t;

  localparam logic [1:0] PRED_SGE = 2'd0;
  localparam logic [1:0] PRED_SGT = 2'd1;
  localparam logic [1:0] PRED_UGE = 2'd2;

  localparam logic [WIDTH-1:0] CAND_LAST = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, a_nxt;
  logic [WIDTH-1:0] b_r, b_nxt;
  logic [1:0]       pred_r, pred_nxt;
  logic [WIDTH-1:0] cand, cand_nxt;
  logic [WIDTH-1:0] prod, prod_nxt;
  logic             done_nxt;
  logic             found_nxt;
  logic [WIDTH-1:0] x_nxt;
  logic             hit;
  logic             last;

  // prod always equals a_r*cand mod 2^WIDTH, so the predicate is evaluated
  // on the current candidate without a multiplier.
  always_comb begin
    hit = 1'b0;
    case (pred_r)
      PRED_SGE: hit = ($signed(prod) >= $signed(b_r));
      PRED_SGT: hit = ($signed(prod) >  $signed(b_r));
      PRED_UGE: hit = (prod >= b_r);
      default:  hit = (prod == b_r);
    endcase
  end

  // Termination is decided on the candidate value itself so cand never wraps.
  assign last  = (cand == CAND_LAST);
  assign ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    a_nxt     = a_r;
    b_nxt     = b_r;
    pred_nxt  = pred_r;
    cand_nxt  = cand;
    prod_nxt  = prod;
    done_nxt  = 1'b0;
    found_nxt = found;
    x_nxt     = x;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SEARCH;
          a_nxt     = a;
          b_nxt     = b;
          pred_nxt  = pred;
          cand_nxt  = '0;
          prod_nxt  = '0;
          found_nxt = 1'b0;
          x_nxt     = '0;
        end
      end
      SEARCH: begin
        if (abort) begin
          state_nxt = IDLE;
          found_nxt = 1'b0;
          x_nxt     = '0;
        end else if (hit) begin
          state_nxt = IDLE;
          found_nxt = 1'b1;
          x_nxt     = cand;
          done_nxt  = 1'b1;
        end else if (last) begin
          state_nxt = IDLE;
          found_nxt = 1'b0;
          x_nxt     = '0;
          done_nxt  = 1'b1;
        end else begin
          cand_nxt  = cand + ONE;
          prod_nxt  = prod + a_r;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      pred_r <= '0;
      cand   <= '0;
      prod   <= '0;
      done   <= 1'b0;
      found  <= 1'b0;
      x      <= '0;
    end else begin
      state  <= state_nxt;
      a_r    <= a_nxt;
      b_r    <= b_nxt;
      pred_r <= pred_nxt;
      cand   <= cand_nxt;
      prod   <= prod_nxt;
      done   <= done_nxt;
      found  <= found_nxt;
      x      <= x_nxt;
    end
  end

endmodule

// File: tb/tb_bvmul_pred_witness.sv
// Bench for bvmul_pred_witness: directed WIDTH=4 scenarios plus a WIDTH=6 random
// sweep, both checked against an exhaustive software search of the predicate.
module tb_bvmul_pred_witness;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, abort4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, x4;
  logic [1:0] p4 = '0;
  logic       rdy4, done4, found4;

  logic       start6 = 1'b0, abort6 = 1'b0;
  logic [5:0] a6 = '0, b6 = '0, x6;
  logic [1:0] p6 = '0;
  logic       rdy6, done6, found6;

  int errors = 0;
  int checks = 0;

  bvmul_pred_witness #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .a(a4), .b(b4), .pred(p4),
    .ready(rdy4), .done(done4), .found(found4), .x(x4)
  );

  bvmul_pred_witness #(.WIDTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .abort(abort6),
    .a(a6), .b(b6), .pred(p6),
    .ready(rdy6), .done(done6), .found(found6), .x(x6)
  );

  // Exhaustive search straight from the predicate definition.
  function automatic void ref_model(input int w, input int av, input int bv, input int pv,
                                    output bit f, output int k);
    int m, p, ps, bs;
    bit h;
    m  = 1 << w;
    f  = 1'b0;
    k  = 0;
    bs = (bv >= m / 2) ? bv - m : bv;
    for (int xx = 0; xx < m && !f; xx++) begin
      p  = (av * xx) % m;
      ps = (p >= m / 2) ? p - m : p;
      case (pv)
        0:       h = (ps >= bs);
        1:       h = (ps > bs);
        2:       h = (p >= bv);
        default: h = (p == bv);
      endcase
      if (h) begin
        f = 1'b1;
        k = xx;
      end
    end
  endfunction

  // Drive one WIDTH=4 request; returns edges from acceptance to done (-1 on
  // timeout) and the outputs seen in the first cycle after acceptance.
  // With b2b=1 the caller is already at the falling edge of a done cycle.
  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic [1:0] pv,
                      input bit b2b, output int lat, output logic rdy0,
                      output logic found0, output logic [3:0] x0);
    if (!b2b) @(negedge clk);
    a4 = av; b4 = bv; p4 = pv; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    rdy0 = rdy4; found0 = found4; x0 = x4;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done4) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", rdy4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done4); end
    checks++; if (found4 !== 1'b0) begin errors++; $display("FAIL reset_found got=%0b exp=0", found4); end
    checks++; if (x4 !== 4'd0) begin errors++; $display("FAIL reset_x got=%0d exp=0", x4); end
    checks++; if (rdy6 !== 1'b1) begin errors++; $display("FAIL reset_ready6 got=%0b exp=1", rdy6); end
    rst_n = 1'b1;
  endtask

  task automatic test_sge;
    int lat; logic r0, f0; logic [3:0] x0;
    run4(4'd3, 4'd5, 2'd0, 1'b0, lat, r0, f0, x0);
    checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL sge_busy_ready got=%0b exp=0", r0); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL sge_latency got=%0d exp=3", lat); end
    checks++; if (found4 !== 1'b1) begin errors++; $display("FAIL sge_found got=%0b exp=1", found4); end
    checks++; if (x4 !== 4'd2) begin errors++; $display("FAIL sge_x got=%0d exp=2", x4); end
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL sge_done_ready got=%0b exp=1", rdy4); end
    @(negedge clk);
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL sge_done_width got=%0b exp=0", done4); end
  endtask

  task automatic test_sgt;
    int lat; logic r0, f0; logic [3:0] x0;
    run4(4'hF, 4'd6, 2'd1, 1'b0, lat, r0, f0, x0);
    // previous result must be cleared by the accepted start
    checks++; if ({f0, x0} !== 5'd0) begin errors++; $display("FAIL sgt_clear got=%0d exp=0", {f0, x0}); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL sgt_latency got=%0d exp=10", lat); end
    checks++; if (found4 !== 1'b1) begin errors++; $display("FAIL sgt_found got=%0b exp=1", found4); end
    checks++; if (x4 !== 4'd9) begin errors++; $display("FAIL sgt_x got=%0d exp=9", x4); end
  endtask

  task automatic test_uge_unsat;
    int lat; logic r0, f0; logic [3:0] x0;
    run4(4'd4, 4'd13, 2'd2, 1'b0, lat, r0, f0, x0);
    checks++; if (lat !== 16) begin errors++; $display("FAIL uge_latency got=%0d exp=16", lat); end
    checks++; if (found4 !== 1'b0) begin errors++; $display("FAIL uge_found got=%0b exp=0", found4); end
    checks++; if (x4 !== 4'd0) begin errors++; $display("FAIL uge_x got=%0d exp=0", x4); end
  endtask

  task automatic test_back_to_back;
    int lat; logic r0, f0; logic [3:0] x0;
    run4(4'd3, 4'd1, 2'd3, 1'b0, lat, r0, f0, x0);
    checks++; if (lat !== 12) begin errors++; $display("FAIL eq_latency got=%0d exp=12", lat); end
    checks++; if (found4 !== 1'b1) begin errors++; $display("FAIL eq_found got=%0b exp=1", found4); end
    checks++; if (x4 !== 4'd11) begin errors++; $display("FAIL eq_x got=%0d exp=11", x4); end
    run4(4'd5, 4'h8, 2'd0, 1'b1, lat, r0, f0, x0);
    checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_latency got=%0d exp=1", lat); end
    checks++; if (found4 !== 1'b1) begin errors++; $display("FAIL b2b_found got=%0b exp=1", found4); end
    checks++; if (x4 !== 4'd0) begin errors++; $display("FAIL b2b_x got=%0d exp=0", x4); end
  endtask

  task automatic test_robust;
    bit saw_done;
    // abort at cycle 5 of an unsatisfiable search
    @(negedge clk);
    a4 = 4'd0; b4 = 4'd1; p4 = 2'd0; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); @(negedge clk);
      saw_done |= done4;
    end
    abort4 = 1'b1;
    @(posedge clk); @(negedge clk);
    abort4 = 1'b0;
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL abort_ready got=%0b exp=1", rdy4); end
    checks++; if ({found4, x4} !== 5'd0) begin errors++; $display("FAIL abort_result got=%0d exp=0", {found4, x4}); end
    repeat (20) begin
      saw_done |= done4;
      @(negedge clk);
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%0b exp=0", saw_done); end

    // reset at cycle 7 of a restarted search
    start4 = 1'b1;
    @(posedge clk); @(negedge clk);
    start4 = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); @(negedge clk);
      saw_done |= done4;
    end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({rdy4, done4, found4, x4} !== 7'b1000000) begin
      errors++; $display("FAIL rst_mid_outputs got=%b exp=1000000", {rdy4, done4, found4, x4});
    end
    repeat (20) begin
      saw_done |= done4;
      @(negedge clk);
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_no_done got=%0b exp=0", saw_done); end

    // start toggling with other operands during a search must not disturb it
    a4 = 4'hF; b4 = 4'd6; p4 = 2'd1; start4 = 1'b1;
    @(posedge clk); @(negedge clk);
    start4 = 1'b0;
    begin
      int lat;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
        if (c <= 6) begin
          start4 = c[0]; a4 = 4'd1; b4 = 4'd0; p4 = 2'd3;
        end else begin
          start4 = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        if (done4) begin lat = c; break; end
      end
      checks++; if (lat !== 10) begin errors++; $display("FAIL toggle_latency got=%0d exp=10", lat); end
      checks++; if ({found4, x4} !== {1'b1, 4'd9}) begin
        errors++; $display("FAIL toggle_result got=%0d/%0d exp=1/9", found4, x4);
      end
    end
  endtask

  task automatic test_sweep6;
    int av, bv, pv, k, lat, exp_lat, exp_x;
    bit f;
    for (int t = 0; t < 1000; t++) begin
      av = int'($urandom_range(63, 0));
      bv = int'($urandom_range(63, 0));
      pv = int'($urandom_range(3, 0));
      ref_model(6, av, bv, pv, f, k);
      exp_lat = f ? k + 1 : 64;
      exp_x   = f ? k : 0;
      @(negedge clk);
      a6 = av[5:0]; b6 = bv[5:0]; p6 = pv[1:0]; start6 = 1'b1;
      @(posedge clk); @(negedge clk);
      start6 = 1'b0;
      lat = -1;
      for (int c = 1; c <= 80; c++) begin
        @(posedge clk); @(negedge clk);
        if (done6) begin lat = c; break; end
      end
      checks++; if (lat !== exp_lat) begin
        errors++; $display("FAIL sweep_latency a=%0d b=%0d p=%0d got=%0d exp=%0d", av, bv, pv, lat, exp_lat);
      end
      checks++; if (found6 !== f) begin
        errors++; $display("FAIL sweep_found a=%0d b=%0d p=%0d got=%0b exp=%0b", av, bv, pv, found6, f);
      end
      checks++; if (int'(x6) !== exp_x) begin
        errors++; $display("FAIL sweep_x a=%0d b=%0d p=%0d got=%0d exp=%0d", av, bv, pv, x6, exp_x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sge();
    test_sgt();
    test_uge_unsat();
    test_back_to_back();
    test_robust();
    test_sweep6();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
